mem_access_ctrl: RTL and testbench

- Memory-stage controller between the EX/MEM latch and the MEM/WB latch.
- Issues data-memory read/write requests for the instruction held in EX/MEM and holds the pipeline until the cache answers.
- Captures load data so the MEM/WB latch sees a stable dmem_load value.
- Maintains the LL/SC link register and enforces the halt sequence, so no request is issued twice under freeze.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/link_reg.sv | 66 ++++++
 rtl/mem_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU type definitions used by the memory-stage controller.
//   word_t      : 32-bit data word
//   mem_state_t : memory-stage access state (IDLE / WAIT / DONE)
//   SC_SUCCESS  : value returned to the register file by a successful SC
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // IDLE : no access outstanding, a new request may be issued this cycle
    // WAIT : request issued, waiting for the cache to answer with dhit
    // DONE : access served but the instruction is still frozen in EX/MEM
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam word_t SC_SUCCESS = 32'h1;

endpackage

// File: rtl/link_reg.sv
// ---------------------------------------------------------------------------
// link_reg
// LL/SC link register: remembers the word address reserved by the last LL
// and drops the reservation on SC completion, on a local store to the linked
// word, or on a coherence invalidate of that word.
// Ports:
//   CLK, nRST      : clock, asynchronous active-low reset
//   set_i          : an LL completed this cycle
//   setAddr_i      : address of that LL
//   scClear_i      : an SC completed (success or fail) this cycle
//   storeHit_i     : a plain store completed this cycle
//   storeAddr_i    : address of that store
//   snoopInv_i     : coherence invalidate this cycle
//   snoopAddr_i    : invalidated word address
//   linkValid_o    : reservation is held
//   linkAddr_o     : reserved word address
// ---------------------------------------------------------------------------
module link_reg #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] setAddr_i,
    input  logic              scClear_i,
    input  logic              storeHit_i,
    input  logic [ADDR_W-1:0] storeAddr_i,
    input  logic              snoopInv_i,
    input  logic [ADDR_W-1:0] snoopAddr_i,
    output logic              linkValid_o,
    output logic [ADDR_W-1:0] linkAddr_o
);

    logic              linkValid_q, linkValid_d;
    logic [ADDR_W-1:0] linkAddr_q, linkAddr_d;

    // A new LL beats every clear in the same cycle, but a snoop that hits the
    // freshly linked address must still kill the reservation, otherwise the
    // invalidate would be lost.
    always_comb begin
        linkValid_d = linkValid_q;
        linkAddr_d  = linkAddr_q;
        if (set_i) begin
            linkAddr_d  = setAddr_i;
            linkValid_d = ~(snoopInv_i && (snoopAddr_i == setAddr_i));
        end else if (scClear_i
                  || (storeHit_i && (storeAddr_i == linkAddr_q))
                  || (snoopInv_i && (snoopAddr_i == linkAddr_q))) begin
            linkValid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            linkValid_q <= 1'b0;
            linkAddr_q  <= '0;
        end else begin
            linkValid_q <= linkValid_d;
            linkAddr_q  <= linkAddr_d;
        end
    end

    assign linkValid_o = linkValid_q;
    assign linkAddr_o  = linkAddr_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Memory-stage controller between EX/MEM and MEM/WB. Issues data-cache
// requests for the EX/MEM instruction, stalls the pipeline until dhit,
// captures load data for MEM/WB, keeps the LL/SC link and the sticky halt.
// Ports:
//   CLK, nRST               : clock, asynchronous active-low reset
//   valid_i..halt_i         : decoded EX/MEM instruction controls
//   addr_i, store_i         : effective address and store data
//   freeze, flush           : hazard-unit controls for EX/MEM
//   dhit, dmemload          : cache completion and read data
//   snoop_inv, snoop_addr   : coherence invalidate
//   dmemREN/WEN/addr/store  : cache request
//   mem_stall               : freeze IF..EX/MEM while the access is pending
//   dmem_load_o             : load value to MEM/WB
//   halt_o                  : sticky halt
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit HALT_DRAIN = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              valid_i,
    input  logic              dREN_i,
    input  logic              dWEN_i,
    input  logic              ll_i,
    input  logic              sc_i,
    input  logic              halt_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] store_i,
    input  logic              freeze,
    input  logic              flush,
    input  logic              dhit,
    input  logic [ADDR_W-1:0] dmemload,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [ADDR_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] dmem_load_o,
    output logic              halt_o
);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] loadBuf_q, loadBuf_d;
    logic              halt_q, halt_d;

    logic              linkValid;
    logic [ADDR_W-1:0] linkAddr;

    logic              need;
    logic              scFail;
    logic              issueIdle;
    logic              reqActive;
    logic              hitAccepted;
    logic              scFailNow;
    logic              haltSet;
    logic [ADDR_W-1:0] hitValue;

    // Request qualification. nRST is folded into need so that the
    // combinational request path drops the moment reset is asserted, not
    // only once the state register has been cleared.
    always_comb begin
        need        = nRST & valid_i & (dREN_i | dWEN_i) & ~flush & ~halt_q;
        scFail      = sc_i & ~(linkValid & (linkAddr == addr_i));
        issueIdle   = (state_q == IDLE) & need & ~scFail;
        reqActive   = issueIdle | ((state_q == WAIT) & need);
        hitAccepted = reqActive & dhit;
        scFailNow   = (state_q == IDLE) & need & scFail;
        hitValue    = sc_i ? ADDR_W'(SC_SUCCESS) : dmemload;
    end

    // Cache request and stall outputs. DONE never drives a request, which is
    // what prevents a re-issue while the served instruction sits frozen.
    always_comb begin
        dmemREN     = reqActive & dREN_i;
        dmemWEN     = reqActive & dWEN_i;
        dmemaddr    = reqActive ? addr_i : '0;
        dmemstore   = (reqActive & dWEN_i) ? store_i : '0;
        mem_stall   = reqActive & ~dhit;
        dmem_load_o = hitAccepted ? hitValue
                    : (scFailNow ? '0 : loadBuf_q);
    end

    // Next-state logic. Losing need while in WAIT means the instruction was
    // flushed, so the outstanding request is simply abandoned.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issueIdle) begin
                    if (dhit) state_d = freeze ? DONE : IDLE;
                    else      state_d = WAIT;
                end
            end
            WAIT: begin
                if (!need)     state_d = IDLE;
                else if (dhit) state_d = freeze ? DONE : IDLE;
            end
            DONE: begin
                if (!freeze || flush) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load buffer keeps the last value so MEM/WB sees it stable across
    // freeze. A failing SC writes 0 so its result also holds steady.
    always_comb begin
        loadBuf_d = loadBuf_q;
        if (hitAccepted && (dREN_i || sc_i)) loadBuf_d = hitValue;
        else if (scFailNow)                  loadBuf_d = '0;
    end

    // With HALT_DRAIN the halt waits until nothing is in flight or about to
    // be issued, so an access is never cut off halfway.
    always_comb begin
        haltSet = valid_i & halt_i & ~flush & ~freeze
                & (HALT_DRAIN ? ((state_q == IDLE) & ~need) : 1'b1);
        halt_d  = halt_q | haltSet;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            loadBuf_q <= '0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            loadBuf_q <= loadBuf_d;
            halt_q    <= halt_d;
        end
    end

    assign halt_o = halt_q;

    link_reg #(
        .ADDR_W (ADDR_W)
    ) uLinkReg (
        .CLK         (CLK),
        .nRST        (nRST),
        .set_i       (hitAccepted & ll_i & dREN_i),
        .setAddr_i   (addr_i),
        .scClear_i   ((hitAccepted & sc_i) | scFailNow),
        .storeHit_i  (hitAccepted & dWEN_i & ~sc_i),
        .storeAddr_i (addr_i),
        .snoopInv_i  (snoop_inv),
        .snoopAddr_i (snoop_addr),
        .linkValid_o (linkValid),
        .linkAddr_o  (linkAddr)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl: LW with wait states, SW under freeze,
// LL/SC success and failure, link clearing, flush in WAIT, async reset in
// WAIT and sticky halt.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        valid_i, dREN_i, dWEN_i, ll_i, sc_i, halt_i;
    logic [31:0] addr_i, store_i;
    logic        freeze, flush, dhit;
    logic [31:0] dmemload;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        mem_stall;
    logic [31:0] dmem_load_o;
    logic        halt_o;

    int vectors    = 0;
    int miscompares = 0;

    mem_access_ctrl #(
        .ADDR_W     (32),
        .HALT_DRAIN (1'b1)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .valid_i     (valid_i),
        .dREN_i      (dREN_i),
        .dWEN_i      (dWEN_i),
        .ll_i        (ll_i),
        .sc_i        (sc_i),
        .halt_i      (halt_i),
        .addr_i      (addr_i),
        .store_i     (store_i),
        .freeze      (freeze),
        .flush       (flush),
        .dhit        (dhit),
        .dmemload    (dmemload),
        .snoop_inv   (snoop_inv),
        .snoop_addr  (snoop_addr),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .dmemaddr    (dmemaddr),
        .dmemstore   (dmemstore),
        .mem_stall   (mem_stall),
        .dmem_load_o (dmem_load_o),
        .halt_o      (halt_o)
    );

    // 10-unit clock period, rising edges at 5, 15, 25, ...
    always #5 CLK = ~CLK;

    // The hazard unit must never flush a store that is still waiting on the
    // cache, because a dropped write cannot be recovered.
    always @(negedge CLK) begin
        if (nRST && dut.state_q == WAIT && dWEN_i && flush) begin
            miscompares++;
            $error("[TB] FAIL flushed_stalled_store observed=1 expected=0");
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one instruction in EX/MEM; cache and hazard inputs are set
    // separately by the caller.
    task automatic applyStimulus(input logic vld, input logic ren, input logic wen,
                                 input logic ll, input logic sc, input logic hlt,
                                 input logic [31:0] addr, input logic [31:0] data);
        valid_i = vld;
        dREN_i  = ren;
        dWEN_i  = wen;
        ll_i    = ll;
        sc_i    = sc;
        halt_i  = hlt;
        addr_i  = addr;
        store_i = data;
    endtask

    task automatic clearInputs();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        freeze     = 1'b0;
        flush      = 1'b0;
        dhit       = 1'b0;
        dmemload   = 32'h0;
        snoop_inv  = 1'b0;
        snoop_addr = 32'h0;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        clearInputs();
        nRST = 1'b0;
        #2;
        // Reset values
        checkOutput("rst_dmemREN",   {31'b0, dmemREN},   32'h0);
        checkOutput("rst_dmemWEN",   {31'b0, dmemWEN},   32'h0);
        checkOutput("rst_mem_stall", {31'b0, mem_stall}, 32'h0);
        checkOutput("rst_halt_o",    {31'b0, halt_o},    32'h0);
        checkOutput("rst_load",      dmem_load_o,        32'h0);
        checkOutput("rst_state",     32'(dut.state_q),   32'(IDLE));
        checkOutput("rst_link",      {31'b0, dut.uLinkReg.linkValid_q}, 32'h0);
        nextCycle();
        nRST = 1'b1;
        nextCycle();

        // LW 0x100, hit three cycles after issue: stall in exactly 3 cycles
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h100, 32'h0);
        #2;
        checkOutput("lw_c0_ren",   {31'b0, dmemREN},   32'h1);
        checkOutput("lw_c0_addr",  dmemaddr,           32'h100);
        checkOutput("lw_c0_stall", {31'b0, mem_stall}, 32'h1);
        nextCycle();
        #2;
        checkOutput("lw_c1_state", 32'(dut.state_q),   32'(WAIT));
        checkOutput("lw_c1_stall", {31'b0, mem_stall}, 32'h1);
        checkOutput("lw_c1_ren",   {31'b0, dmemREN},   32'h1);
        nextCycle();
        #2;
        checkOutput("lw_c2_stall", {31'b0, mem_stall}, 32'h1);
        nextCycle();
        dhit = 1'b1; dmemload = 32'hDEADBEEF;
        #2;
        checkOutput("lw_c3_stall", {31'b0, mem_stall}, 32'h0);
        checkOutput("lw_c3_load",  dmem_load_o,        32'hDEADBEEF);
        nextCycle();
        clearInputs();
        #2;
        checkOutput("lw_hold_load",  dmem_load_o,        32'hDEADBEEF);
        checkOutput("lw_hold_state", 32'(dut.state_q),   32'(IDLE));
        checkOutput("lw_hold_ren",   {31'b0, dmemREN},   32'h0);

        // SW 0x40 data 0x1234, same-cycle hit, freeze for 2 cycles
        nextCycle();
        applyStimulus(1, 0, 1, 0, 0, 0, 32'h40, 32'h1234);
        dhit = 1'b1; freeze = 1'b1;
        #2;
        checkOutput("sw_a_wen",   {31'b0, dmemWEN},   32'h1);
        checkOutput("sw_a_store", dmemstore,          32'h1234);
        checkOutput("sw_a_stall", {31'b0, mem_stall}, 32'h0);
        nextCycle();
        dhit = 1'b0;
        #2;
        checkOutput("sw_b_state", 32'(dut.state_q),   32'(DONE));
        checkOutput("sw_b_wen",   {31'b0, dmemWEN},   32'h0);
        checkOutput("sw_b_stall", {31'b0, mem_stall}, 32'h0);
        nextCycle();
        freeze = 1'b0;
        #2;
        checkOutput("sw_c_state", 32'(dut.state_q),   32'(DONE));
        checkOutput("sw_c_wen",   {31'b0, dmemWEN},   32'h0);
        nextCycle();
        clearInputs();
        #2;
        checkOutput("sw_d_state", 32'(dut.state_q),   32'(IDLE));

        // LL 0x80 hit, then SC 0x80 data 7 succeeds
        nextCycle();
        applyStimulus(1, 1, 0, 1, 0, 0, 32'h80, 32'h0);
        dhit = 1'b1; dmemload = 32'h55;
        #2;
        checkOutput("ll_load",  dmem_load_o,        32'h55);
        checkOutput("ll_stall", {31'b0, mem_stall}, 32'h0);
        nextCycle();
        applyStimulus(1, 0, 1, 0, 1, 0, 32'h80, 32'h7);
        dhit = 1'b0; dmemload = 32'h0;
        #2;
        checkOutput("ll_linked", {31'b0, dut.uLinkReg.linkValid_q}, 32'h1);
        checkOutput("sc_wen",    {31'b0, dmemWEN},   32'h1);
        checkOutput("sc_store",  dmemstore,          32'h7);
        nextCycle();
        dhit = 1'b1;
        #2;
        checkOutput("sc_ok_load", dmem_load_o, 32'h1);
        nextCycle();
        clearInputs();
        #2;
        checkOutput("sc_link_clr", {31'b0, dut.uLinkReg.linkValid_q}, 32'h0);
        checkOutput("sc_ok_hold",  dmem_load_o, 32'h1);

        // LL 0x80, snoop invalidate 0x80, then SC 0x80 fails silently
        nextCycle();
        applyStimulus(1, 1, 0, 1, 0, 0, 32'h80, 32'h0);
        dhit = 1'b1; dmemload = 32'h66;
        nextCycle();
        clearInputs();
        snoop_inv = 1'b1; snoop_addr = 32'h80;
        nextCycle();
        clearInputs();
        applyStimulus(1, 0, 1, 0, 1, 0, 32'h80, 32'h9);
        #2;
        checkOutput("snoop_link",   {31'b0, dut.uLinkReg.linkValid_q}, 32'h0);
        checkOutput("scf_wen",      {31'b0, dmemWEN},   32'h0);
        checkOutput("scf_load",     dmem_load_o,        32'h0);
        checkOutput("scf_stall",    {31'b0, mem_stall}, 32'h0);

        // LL 0x90 then a plain SW hit to 0x90 clears the link
        nextCycle();
        clearInputs();
        applyStimulus(1, 1, 0, 1, 0, 0, 32'h90, 32'h0);
        dhit = 1'b1; dmemload = 32'h77;
        nextCycle();
        applyStimulus(1, 0, 1, 0, 0, 0, 32'h90, 32'h5);
        #2;
        checkOutput("ll90_link", {31'b0, dut.uLinkReg.linkValid_q}, 32'h1);
        nextCycle();
        clearInputs();
        #2;
        checkOutput("sw90_link", {31'b0, dut.uLinkReg.linkValid_q}, 32'h0);

        // LW pending in WAIT, then flushed
        nextCycle();
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h200, 32'h0);
        #2;
        checkOutput("fl_ren0", {31'b0, dmemREN}, 32'h1);
        nextCycle();
        flush = 1'b1;
        #2;
        checkOutput("fl_state_wait", 32'(dut.state_q), 32'(WAIT));
        nextCycle();
        clearInputs();
        #2;
        checkOutput("fl_ren",   {31'b0, dmemREN}, 32'h0);
        checkOutput("fl_state", 32'(dut.state_q), 32'(IDLE));

        // Reset asserted between edges while a LW waits
        nextCycle();
        applyStimulus(1, 1, 0, 1, 0, 0, 32'h80, 32'h0);
        dhit = 1'b1; dmemload = 32'h88;
        nextCycle();
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h100, 32'h0);
        dhit = 1'b0;
        nextCycle();
        #1;
        checkOutput("mr_state", 32'(dut.state_q), 32'(WAIT));
        checkOutput("mr_link",  {31'b0, dut.uLinkReg.linkValid_q}, 32'h1);
        checkOutput("mr_ren",   {31'b0, dmemREN}, 32'h1);
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("ar_ren",   {31'b0, dmemREN},   32'h0);
        checkOutput("ar_stall", {31'b0, mem_stall}, 32'h0);
        checkOutput("ar_link",  {31'b0, dut.uLinkReg.linkValid_q}, 32'h0);
        checkOutput("ar_state", 32'(dut.state_q),   32'(IDLE));
        clearInputs();
        nextCycle();
        nRST = 1'b1;
        nextCycle();

        // HALT becomes sticky and blocks later requests
        applyStimulus(1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        #2;
        checkOutput("halt_pre", {31'b0, halt_o}, 32'h0);
        nextCycle();
        clearInputs();
        #2;
        checkOutput("halt_set", {31'b0, halt_o}, 32'h1);
        nextCycle();
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h300, 32'h0);
        #2;
        checkOutput("halt_ren",   {31'b0, dmemREN},   32'h0);
        checkOutput("halt_stall", {31'b0, mem_stall}, 32'h0);
        checkOutput("halt_addr",  dmemaddr,           32'h0);
        nextCycle();
        #2;
        checkOutput("halt_sticky", {31'b0, halt_o}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
